fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the MIPS CPU. It owns the program counter, drives the fetch address into the combinational instruction memory (`im`), captures the returned word into a 2-entry fetch queue, and presents it to decode over a valid/ready handshake. Branch and jump resolution redirects the PC and flushes the queue. Out-of-range or misaligned fetch addresses produce a tagged fault entry instead of an instruction.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value after reset; also the base of the instruction memory window.
- `IM_WORDS`, default 4096: instruction memory size in words. The valid window is [RESET_PC, RESET_PC + 4*IM_WORDS).
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `pc` output 32: current fetch address, driven to `im`.
- `instr` input 32: word returned by `im` for `pc`, valid in the same cycle.
- `redirect` input 1: a branch/jump/jr was taken this cycle.
- `redirect_pc` input 32: target address, sampled when `redirect` = 1.
- `id_ready` input 1: decode accepts the head entry this cycle.
- `id_valid` output 1: the head entry is valid.
- `id_instr` output 32: head instruction word; 0 for fault entries.
- `id_pc` output 32: address the head entry was fetched from.
- `id_fault` output 1: the head entry is a fetch fault.

## Operation
- **Queue:** 2 entries of {pc, instr, fault}, with read/write pointers and a 2-bit count (0..2). Head is at the read pointer.
- **`id_valid`:** = (count != 0) & ~redirect. A handshake completes when `id_valid` & `id_ready`; that pops the head.
- **`fault_now`:** = (`pc` < RESET_PC) | (`pc` >= RESET_PC + 4*IM_WORDS) | (`pc[1:0]` != 0). Comparisons are 32-bit unsigned.
- **FSM states:** FETCH and FAULT_WAIT.
- **Push** occurs when state = FETCH, count < 2 (evaluated at the start of the cycle), and `redirect` = 0.
  - Normal push: enqueue {`pc`, `instr`, 0}; `pc` <= `pc` + 4. The addition is modulo 2^32.
  - Fault push (`fault_now`): enqueue {`pc`, 0, 1}; `pc` holds; state -> FAULT_WAIT.
- **FAULT_WAIT:** no pushes and `pc` holds. Queued entries still drain. The only exit is `redirect`.
- **Redirect** has the highest priority:
  - count <= 0 and pointers <= 0.
  - `pc` <= `redirect_pc`.
  - state -> FETCH.
  - No push and no pop in that cycle.
- **Push and pop in the same cycle:**
  - At count = 1: count stays 1.
  - At count = 2: the pop is allowed but the push is blocked. There is no push-through on full.
- **Empty queue:** `id_instr`, `id_pc` and `id_fault` show stale entry contents. Decode must ignore them while `id_valid` = 0.

## Timing
- **Reset (asserted low, asynchronous):**
  - `pc` = RESET_PC, state = FETCH, count = 0, pointers = 0.
  - All queue entries cleared to 0, so `id_valid` = 0, `id_instr` = 0, `id_pc` = 0, `id_fault` = 0.
- **Startup latency:** the first edge after reset deassertion pushes the word at RESET_PC. `id_valid` rises in the following cycle, so load-to-use latency is 1 cycle.
- **Redirect latency:**
  - `redirect` high at edge N.
  - `pc` = target during cycle N+1.
  - The target word is visible on `id_*` with `id_valid` = 1 in cycle N+2.
- **Throughput:** with `id_ready` held at 1, one instruction per cycle.
- **Backpressure:** with `id_ready` = 0, the queue fills in 2 cycles and `pc` then holds. One cycle after `id_ready` returns, fetching resumes with no lost or duplicated word.
- **Window end:** the word at RESET_PC + 4*IM_WORDS − 4 (0x6FFC by default) is fetched normally. The next address (0x7000) produces a fault entry.
- **Reset mid-operation:** asynchronous clear to the reset values above. Queue contents are discarded.
- All outputs are registered or derived from registered state plus `redirect`. There is no combinational path from `id_ready` to `pc`.

## Test plan
- **Reset and sequential fetch:** reset low, then release with `id_ready` = 1 and `im` holding words W0..W3 at 0x3000..0x300C. Expect `id_pc` = 0x3000, 0x3004, 0x3008, 0x300C with the matching `id_instr`, one per cycle, starting 1 cycle after release.
- **Backpressure:** hold `id_ready` = 0 for 5 cycles. Expect `pc` to stop at 0x3008 with count = 2. Release `id_ready`; expect an in-order stream 0x3000, 0x3004, 0x3008, 0x300C with no gaps or duplicates.
- **Redirect flush:** with the queue full, pulse `redirect` with `redirect_pc` = 0x3100. Expect `id_valid` = 0 that cycle, `pc` = 0x3100 next cycle, then `id_pc` = 0x3100 two cycles after the pulse; no old entries emerge.
- **Faults:**
  - Redirect to 0x3002: expect one entry with `id_fault` = 1, `id_instr` = 0, `id_pc` = 0x3002, after which `pc` holds.
  - Then redirect to 0x3000: fetch resumes normally.
- **Window end and fault hold:** redirect to 0x6FF8. Expect normal entries at 0x6FF8 and 0x6FFC, then a fault entry at 0x7000. No further pushes occur while in FAULT_WAIT.
- **Asynchronous reset mid-stream:** assert reset between clock edges. Expect `id_valid` = 0 and `pc` = 0x3000 immediately, with no clock edge required.

Source files
------------

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Fetch-to-decode handshake bundle. The fetch stage presents
//               the head queue entry; decode answers with id_ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        id_fault;

   // Fetch side drives the entry, decode side drives the acceptance.
   modport master (
      output id_valid,
      output id_instr,
      output id_pc,
      output id_fault,
      input  id_ready
   );

   modport slave (
      input  id_valid,
      input  id_instr,
      input  id_pc,
      input  id_fault,
      output id_ready
   );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : MIPS instruction fetch stage. Owns the PC, reads a
//               combinational instruction memory, buffers words in a 2-entry
//               queue and hands them to decode. Redirects flush the queue;
//               out-of-window or misaligned fetches yield a fault entry.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          IM_WORDS = 4096
) (
   input  wire logic        clk,
   input  wire logic        reset,
   output      logic [31:0] pc,
   input  wire logic [31:0] instr,
   input  wire logic        redirect,
   input  wire logic [31:0] redirect_pc,
   fetch_unit_if.master     dec
);

   // One past the last valid byte address; 33 bits so the bound cannot wrap.
   localparam logic [32:0] WIN_END = {1'b0, RESET_PC} + (33'(IM_WORDS) << 2);

   typedef enum logic [0:0] {
      FETCH      = 1'b0,
      FAULT_WAIT = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [31:0] q_pc    [2];
   logic [31:0] q_instr [2];
   logic [1:0]  q_fault;
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  count;

   logic        fault_now;
   logic        valid;
   logic        push;
   logic        pop;

   assign fault_now = (pc < RESET_PC) | ({1'b0, pc} >= WIN_END) | (pc[1:0] != 2'b00);
   // A redirect hides the head so decode never consumes a flushed entry.
   assign valid     = (count != 2'd0) & ~redirect;
   assign pop       = valid & dec.id_ready;

   // Next-state and push decision; push never depends on id_ready, so a
   // full queue blocks fetch even when decode is draining this cycle.
   always_comb begin
      state_next = state;
      push       = 1'b0;
      if (redirect) begin
         state_next = FETCH;
      end else begin
         case (state)
            FETCH: begin
               if (count < 2'd2) begin
                  push = 1'b1;
                  if (fault_now) begin
                     state_next = FAULT_WAIT;
                  end
               end
            end
            FAULT_WAIT: begin
               state_next = FAULT_WAIT;
            end
            default: begin
               state_next = FETCH;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   // Program counter: redirect wins, a fault push leaves the PC parked.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         pc <= redirect_pc;
      end else if (push && !fault_now) begin
         pc <= pc + 32'd4;
      end
   end

   // Fetch queue storage, pointers and occupancy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_pc[0]    <= 32'd0;
         q_pc[1]    <= 32'd0;
         q_instr[0] <= 32'd0;
         q_instr[1] <= 32'd0;
         q_fault    <= 2'b00;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         count      <= 2'd0;
      end else if (redirect) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            q_pc[wr_ptr]    <= pc;
            q_instr[wr_ptr] <= fault_now ? 32'd0 : instr;
            q_fault[wr_ptr] <= fault_now;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign dec.id_valid = valid;
   assign dec.id_instr = q_instr[rd_ptr];
   assign dec.id_pc    = q_pc[rd_ptr];
   assign dec.id_fault = q_fault[rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. Every reset or redirect
//               pushes the instruction stream it should produce into a
//               scoreboard; a negedge monitor pops and compares on each
//               decode handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   localparam logic [31:0] BASE  = 32'h0000_3000;
   localparam int          WORDS = 4096;
   localparam longint      WEND  = longint'(BASE) + 4 * WORDS;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } entry_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        redirect;
   logic [31:0] redirect_pc;

   int checks = 0;
   int errors = 0;

   entry_t sb[$];

   fetch_unit_if dif ();

   fetch_unit #(
      .RESET_PC (BASE),
      .IM_WORDS (WORDS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pc          (pc),
      .instr       (instr),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .dec         (dif.master)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: an address hash, readable for any address.
   function automatic logic [31:0] im_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   assign instr = im_word(pc);

   function automatic bit is_fault(input logic [31:0] a);
      return (longint'(a) < longint'(BASE)) || (longint'(a) >= WEND) || (a % 4 != 0);
   endfunction

   // Expected delivery order from a start address: sequential words until the
   // first bad address, which yields one fault entry and then nothing more.
   task automatic push_stream(input logic [31:0] start);
      logic [31:0] a;
      entry_t      e;
      a = start;
      for (int i = 0; i < 64; i++) begin
         e.pc    = a;
         e.fault = is_fault(a);
         e.instr = e.fault ? 32'd0 : im_word(a);
         sb.push_back(e);
         if (e.fault) break;
         a = a + 32'd4;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a handshake is committed at the next rising edge, and inputs are
   // stable from here until then.
   always @(negedge clk) begin
      entry_t e;
      if (reset === 1'b1 && dif.id_valid === 1'b1 && dif.id_ready === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_entry: got pc %h expected no entry", dif.id_pc);
         end else begin
            e = sb.pop_front();
            chk("entry_pc", dif.id_pc, e.pc);
            chk("entry_instr", dif.id_instr, e.instr);
            chk("entry_fault", {31'd0, dif.id_fault}, {31'd0, e.fault});
         end
      end
   end

   // Redirect for one cycle; on return we sit in the cycle where pc = target.
   task automatic do_redirect(input logic [31:0] target, input logic rdy);
      @(posedge clk);
      #1;
      redirect     = 1'b1;
      redirect_pc  = target;
      dif.id_ready = rdy;
      sb.delete();
      push_stream(target);
      @(negedge clk);
      chk("redirect_hides_valid", {31'd0, dif.id_valid}, 32'd0);
      @(posedge clk);
      #1;
      redirect = 1'b0;
      @(negedge clk);
      chk("redirect_pc_next", pc, target);
   endtask

   task automatic run_ready(input int n, input logic rdy);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         dif.id_ready = rdy;
      end
   endtask

   function automatic logic [31:0] rand_target();
      logic [31:0] t;
      case ($urandom_range(0, 4))
         0:       t = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
         1:       t = 32'(WEND) - 32'(4 * $urandom_range(1, 4));
         2:       t = BASE + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(1, 3));
         3:       t = 32'($urandom_range(0, BASE - 1)) & 32'hFFFF_FFFC;
         default: t = 32'(WEND) + 32'(4 * $urandom_range(0, 100));
      endcase
      return t;
   endfunction

   initial begin
      reset        = 1'b0;
      redirect     = 1'b0;
      redirect_pc  = 32'd0;
      dif.id_ready = 1'b1;

      // Reset values.
      #12;
      chk("reset_valid", {31'd0, dif.id_valid}, 32'd0);
      chk("reset_pc", pc, BASE);
      chk("reset_id_instr", dif.id_instr, 32'd0);
      chk("reset_id_pc", dif.id_pc, 32'd0);
      chk("reset_id_fault", {31'd0, dif.id_fault}, 32'd0);

      // Release and stream sequentially with id_ready held high.
      @(posedge clk);
      #1;
      reset = 1'b1;
      push_stream(BASE);
      @(negedge clk);
      chk("pre_first_edge_valid", {31'd0, dif.id_valid}, 32'd0);
      @(negedge clk);
      chk("startup_valid", {31'd0, dif.id_valid}, 32'd1);
      chk("startup_pc", dif.id_pc, BASE);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("throughput_valid", {31'd0, dif.id_valid}, 32'd1);
      end

      // Backpressure: queue fills with 0x3000/0x3004 and pc parks at 0x3008.
      do_redirect(BASE, 1'b0);
      run_ready(5, 1'b0);
      @(negedge clk);
      chk("bp_pc_hold", pc, BASE + 32'h8);
      chk("bp_valid", {31'd0, dif.id_valid}, 32'd1);
      chk("bp_head", dif.id_pc, BASE);
      run_ready(6, 1'b1);

      // Fill again, then flush with a redirect.
      run_ready(3, 1'b0);
      do_redirect(BASE + 32'h100, 1'b1);
      @(negedge clk);
      chk("flush_valid", {31'd0, dif.id_valid}, 32'd1);
      chk("flush_head", dif.id_pc, BASE + 32'h100);
      run_ready(4, 1'b1);

      // Misaligned target: single fault entry, pc parked.
      do_redirect(BASE + 32'h2, 1'b1);
      run_ready(5, 1'b1);
      @(negedge clk);
      chk("fault_pc_hold", pc, BASE + 32'h2);
      chk("fault_drained", {31'd0, dif.id_valid}, 32'd0);
      do_redirect(BASE, 1'b1);
      run_ready(4, 1'b1);

      // Window end: 0x6FF8, 0x6FFC normal, 0x7000 faults.
      do_redirect(32'(WEND) - 32'h8, 1'b1);
      run_ready(7, 1'b1);
      @(negedge clk);
      chk("end_pc_hold", pc, 32'(WEND));
      chk("end_drained", {31'd0, dif.id_valid}, 32'd0);
      chk("end_stream_done", 32'(sb.size()), 32'd0);

      // Randomized redirects and backpressure.
      for (int it = 0; it < 16; it++) begin
         do_redirect(rand_target(), 1'($urandom_range(0, 1)));
         for (int c = 0; c < int'($urandom_range(3, 30)); c++) begin
            @(posedge clk);
            #1;
            dif.id_ready = ($urandom_range(0, 3) != 0);
         end
      end

      // Asynchronous reset between edges.
      do_redirect(BASE + 32'h40, 1'b1);
      run_ready(3, 1'b1);
      @(negedge clk);
      #2;
      reset = 1'b0;
      sb.delete();
      #1;
      chk("async_valid", {31'd0, dif.id_valid}, 32'd0);
      chk("async_pc", pc, BASE);
      chk("async_id_pc", dif.id_pc, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      push_stream(BASE);
      run_ready(6, 1'b1);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
